// File: rtl/led_pwm_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_pkg
// Shared definitions for the RGB LED PWM path. The fade generators import the
// same package, so the period length and duty type stay in step on both sides.
//   c_PWM_INTERVAL_DEFAULT : default PWM period in clk cycles (100us @ 12MHz)
//   duty_t                 : duty word sized for the default period
//   RED / GREEN / BLUE     : colour index constants
// -----------------------------------------------------------------------------
package led_pwm_pkg;

   localparam int unsigned c_PWM_INTERVAL_DEFAULT = 1200;
   localparam int unsigned c_NUM_COLOURS          = 3;

   typedef logic [$clog2(1200)-1:0] duty_t;

   typedef logic [1:0] colour_t;

   localparam colour_t RED   = 2'b00;
   localparam colour_t GREEN = 2'b01;
   localparam colour_t BLUE  = 2'b10;

endpackage : led_pwm_pkg

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One colour of the RGB PWM driver. Holds the pending and active duty
// registers, clamps the duty on capture and registers the compare result as
// the LED drive.
// Optional feature macro: PWM_ACTIVE_LOW_EN (inverted pin, reset level 1).
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   load      in   capture duty into the pending register
//   apply     in   wrap cycle: pending (or a same-cycle capture) becomes active
//   duty      in   requested high-time in clk cycles
//   cnt_next  in   period counter value for the next cycle
//   led       out  registered LED drive
// -----------------------------------------------------------------------------
module pwm_channel #(
   parameter int unsigned c_PWM_INTERVAL = 1200,
   parameter int unsigned c_DUTY_W       = $clog2(c_PWM_INTERVAL)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                apply,
   input  logic [c_DUTY_W-1:0] duty,
   input  logic [c_DUTY_W-1:0] cnt_next,
   output logic                led
);

   localparam logic [c_DUTY_W-1:0] c_FULL = c_DUTY_W'(c_PWM_INTERVAL);

`ifdef PWM_ACTIVE_LOW_EN
   localparam logic c_OFF = 1'b1;
`else
   localparam logic c_OFF = 1'b0;
`endif

   logic [c_DUTY_W-1:0] duty_clamped;
   logic [c_DUTY_W-1:0] pending_q;
   logic [c_DUTY_W-1:0] pending_d;
   logic [c_DUTY_W-1:0] active_q;
   logic [c_DUTY_W-1:0] active_d;
   logic                led_q;
   logic                led_d;

   // Clamp, double buffer and compare for the next cycle.
   always_comb begin
      duty_clamped = (duty > c_FULL) ? c_FULL : duty;

      pending_d = pending_q;
      if (load) begin
         pending_d = duty_clamped;
      end

      // A capture on the wrap cycle bypasses pending so it is not lost a period.
      active_d = active_q;
      if (apply) begin
         active_d = load ? duty_clamped : pending_q;
      end

      // Compare next-cycle counter with next-cycle duty so the flop output
      // edges line up with cnt.
      led_d = (cnt_next < active_d) ^ c_OFF;
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         active_q  <= '0;
         led_q     <= c_OFF;
      end else begin
         pending_q <= pending_d;
         active_q  <= active_d;
         led_q     <= led_d;
      end
   end

   assign led = led_q;

endmodule : pwm_channel

// File: rtl/rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// rgb_pwm_driver
// Drives the RGB LED pins from three duty values supplied by the fade
// generators. A free-running period counter is shared by three pwm_channel
// instances; new duties are double-buffered and applied at the period wrap.
// Optional feature macro: PWM_ACTIVE_LOW_EN (LED pins inverted, reset level 1;
// o_period_start unaffected).
// Ports:
//   clk             in   system clock (12MHz)
//   rst             in   synchronous active-high reset
//   i_duty_r/g/b    in   per-colour high-time in clk cycles per period
//   i_duty_valid    in   1-cycle strobe: capture all three duties
//   o_led_r/g/b     out  registered LED drives
//   o_period_start  out  registered pulse on the cnt==0 cycle of each period
// -----------------------------------------------------------------------------
module rgb_pwm_driver #(
   parameter int unsigned c_PWM_INTERVAL = led_pwm_pkg::c_PWM_INTERVAL_DEFAULT,
   parameter int unsigned c_DUTY_W       = $clog2(c_PWM_INTERVAL)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [c_DUTY_W-1:0] i_duty_r,
   input  logic [c_DUTY_W-1:0] i_duty_g,
   input  logic [c_DUTY_W-1:0] i_duty_b,
   input  logic                i_duty_valid,
   output logic                o_led_r,
   output logic                o_led_g,
   output logic                o_led_b,
   output logic                o_period_start
);

   import led_pwm_pkg::*;

   localparam logic [c_DUTY_W-1:0] c_CNT_LAST = c_DUTY_W'(c_PWM_INTERVAL - 1);

   logic [c_DUTY_W-1:0]      cnt_q;
   logic [c_DUTY_W-1:0]      cnt_d;
   logic                     wrap;
   logic                     period_start_q;
   logic                     period_start_d;
   logic [c_DUTY_W-1:0]      duty_sel [c_NUM_COLOURS];
   logic [c_NUM_COLOURS-1:0] led;

   // Period counter next state and wrap detect.
   always_comb begin
      wrap           = (cnt_q == c_CNT_LAST);
      cnt_d          = wrap ? '0 : cnt_q + c_DUTY_W'(1);
      period_start_d = (cnt_d == '0);
   end

   // Counter and period-start registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         period_start_q <= period_start_d;
      end
   end

   assign duty_sel[RED]   = i_duty_r;
   assign duty_sel[GREEN] = i_duty_g;
   assign duty_sel[BLUE]  = i_duty_b;

   // One compare channel per colour, all sharing the counter.
   for (genvar c = 0; c < c_NUM_COLOURS; c++) begin : g_ch
      pwm_channel #(
         .c_PWM_INTERVAL (c_PWM_INTERVAL),
         .c_DUTY_W       (c_DUTY_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .load     (i_duty_valid),
         .apply    (wrap),
         .duty     (duty_sel[c]),
         .cnt_next (cnt_d),
         .led      (led[c])
      );
   end

   assign o_led_r        = led[RED];
   assign o_led_g        = led[GREEN];
   assign o_led_b        = led[BLUE];
   assign o_period_start = period_start_q;

endmodule : rgb_pwm_driver

// File: tb/tb_rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_driver
// Self-checking bench for rgb_pwm_driver with a 10-cycle period. Expected
// per-cycle pin words {r,g,b,period_start} are queued when stimulus is driven
// and compared as the DUT produces each cycle.
// Honours PWM_ACTIVE_LOW_EN (expected LED levels inverted).
// -----------------------------------------------------------------------------
module tb_rgb_pwm_driver;

   localparam int unsigned c_INT = 10;
   localparam int unsigned c_W   = $clog2(c_INT);

`ifdef PWM_ACTIVE_LOW_EN
   localparam logic c_INV = 1'b1;
`else
   localparam logic c_INV = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [c_W-1:0] i_duty_r;
   logic [c_W-1:0] i_duty_g;
   logic [c_W-1:0] i_duty_b;
   logic           i_duty_valid;
   logic           o_led_r;
   logic           o_led_g;
   logic           o_led_b;
   logic           o_period_start;

   int             checks = 0;
   int             errors = 0;
   int             tb_cnt = 0;
   logic [3:0]     exp_q [$];

   always #5 clk = ~clk;

   rgb_pwm_driver #(
      .c_PWM_INTERVAL (c_INT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_duty_r       (i_duty_r),
      .i_duty_g       (i_duty_g),
      .i_duty_b       (i_duty_b),
      .i_duty_valid   (i_duty_valid),
      .o_led_r        (o_led_r),
      .o_led_g        (o_led_g),
      .o_led_b        (o_led_b),
      .o_period_start (o_period_start)
   );

   // Pin word for a cycle at counter value k with the given active duties.
   function automatic logic [3:0] exp_word(input int k, input int dr,
                                           input int dg, input int db);
      logic r, g, b, ps;
      r  = (k < dr) ^ c_INV;
      g  = (k < dg) ^ c_INV;
      b  = (k < db) ^ c_INV;
      ps = (k == 0);
      return {r, g, b, ps};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      tb_cnt = (tb_cnt + 1) % c_INT;
   endtask

   task automatic run_to(input int target);
      while (tb_cnt != target) tick();
   endtask

   task automatic push_span(input int first, input int n, input int dr,
                            input int dg, input int db);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(exp_word((first + i) % c_INT, dr, dg, db));
      end
   endtask

   task automatic strobe(input int r, input int g, input int b);
      i_duty_r     = c_W'(r);
      i_duty_g     = c_W'(g);
      i_duty_b     = c_W'(b);
      i_duty_valid = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0] e, got;
      rst = 1'b1;
      repeat (3) exp_q.push_back({c_INV, c_INV, c_INV, 1'b0});
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         tb_cnt = 0;
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", got, e);
         end
      end
      rst = 1'b0;
      push_span(1, 30, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL reset_release cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
   endtask

   task automatic test_basic_duty();
      logic [3:0] e, got;
      run_to(4);
      strobe(3, 0, 10);
      push_span(5, 5, 0, 0, 0);
      push_span(0, 10, 3, 0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         i_duty_valid = 1'b0;
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL basic_duty cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
   endtask

   task automatic test_double_buffer();
      logic [3:0] e, got;
      run_to(2);
      strobe(7, 0, 10);
      push_span(3, 7, 3, 0, 10);
      repeat (3) begin
         e = exp_q.pop_front();
         tick();
         i_duty_valid = 1'b0;
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL double_buffer cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
      strobe(4, 0, 10);
      push_span(0, 10, 4, 0, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         i_duty_valid = 1'b0;
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL double_buffer cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
   endtask

   task automatic test_wrap_collision();
      logic [3:0] e, got;
      run_to(9);
      strobe(4, 5, 10);
      push_span(0, 10, 4, 5, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         i_duty_valid = 1'b0;
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL wrap_collision cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
   endtask

   task automatic test_clamp();
      logic [3:0] e, got;
      run_to(3);
      strobe(12, 11, 15);
      push_span(4, 6, 4, 5, 10);
      push_span(0, 20, 10, 10, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         i_duty_valid = 1'b0;
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL clamp cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] e, got;
      run_to(9);
      strobe(8, 0, 0);
      push_span(0, 7, 8, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         i_duty_valid = 1'b0;
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mid_reset_pre cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
      // rst asserted during the cnt==6 cycle
      rst = 1'b1;
      exp_q.push_back({c_INV, c_INV, c_INV, 1'b0});
      e = exp_q.pop_front();
      tick();
      tb_cnt = 0;
      got = {o_led_r, o_led_g, o_led_b, o_period_start};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL mid_reset_assert got=%b exp=%b", got, e);
      end
      rst = 1'b0;
      push_span(1, 19, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mid_reset_post cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
      strobe(2, 2, 2);
      push_span(0, 10, 2, 2, 2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tick();
         i_duty_valid = 1'b0;
         got = {o_led_r, o_led_g, o_led_b, o_period_start};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL mid_reset_recover cnt=%0d got=%b exp=%b", tb_cnt, got, e);
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      i_duty_r     = '0;
      i_duty_g     = '0;
      i_duty_b     = '0;
      i_duty_valid = 1'b0;
      test_reset();
      test_basic_duty();
      test_double_buffer();
      test_wrap_collision();
      test_clamp();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rgb_pwm_driver
